// File: rtl/diagv2_run_ctrl_pkg.sv
// diagv2_run_ctrl_pkg: shared constants and FSM state encoding for the regression sequencer.
//   DATA_BUS_BITS : default width of the core status code (a0/x10)
//   state_t       : sequencer states IDLE, LOAD, RST, RUN, RECORD, DONE
package diagv2_run_ctrl_pkg;
    localparam int DATA_BUS_BITS = 32;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RST,
        S_RUN,
        S_RECORD,
        S_DONE
    } state_t;
endpackage

// File: rtl/diagv2_run_ctrl_if.sv
// diagv2_run_ctrl_if: loader handshake and core control bundle between sequencer and its peers.
//   load_req/load_idx/load_ack : req/ack handshake with the memory loader
//   core_reset/core_en         : reset and clock-enable driven into the core
//   ecall/status_code          : end-of-test indication and a0 value from the core
//   master = sequencer side, slave = loader/core side
interface diagv2_run_ctrl_if #(
    parameter int IDX_W  = 8,
    parameter int DATA_W = 32
) ();
    logic              load_req;
    logic [IDX_W-1:0]  load_idx;
    logic              load_ack;
    logic              core_reset;
    logic              core_en;
    logic              ecall;
    logic [DATA_W-1:0] status_code;
    modport master (
        output load_req, load_idx, core_reset, core_en,
        input  load_ack, ecall, status_code
    );
    modport slave (
        input  load_req, load_idx, core_reset, core_en,
        output load_ack, ecall, status_code
    );
endinterface

// File: rtl/diagv2_run_ctrl_timer.sv
// diagv2_run_timer: saturating run-cycle counter, reset-hold down-counter and watchdog expiry.
//   clk, reset   : clock, asynchronous active-high reset
//   clr, en      : clear / count-enable for run_cycles
//   hold_load    : preload the reset-hold counter with RESET_CYCLES-1
//   hold_dec     : decrement the reset-hold counter
//   hold_zero    : reset-hold counter has reached its final cycle
//   run_cycles   : cycles counted since the last clear, saturating
//   expired      : watchdog limit reached this cycle (DIAGV2_WATCHDOG_EN only, else 0)
module diagv2_run_timer #(
    parameter int TIMEOUT_W      = 20,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RESET_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 hold_load,
    input  logic                 hold_dec,
    output logic                 hold_zero,
    output logic [TIMEOUT_W-1:0] run_cycles,
    output logic                 expired
);
    localparam int HW = $clog2(RESET_CYCLES + 1);
    logic [HW-1:0] hold;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cycles <= '0;
            hold       <= '0;
        end else begin
            run_cycles <= clr ? '0 : (en && run_cycles != '1) ? run_cycles + TIMEOUT_W'(1) : run_cycles;
            hold       <= hold_load ? HW'(RESET_CYCLES - 1) : (hold_dec && hold != '0) ? hold - HW'(1) : hold;
        end
    end
    assign hold_zero = hold == '0;
`ifdef DIAGV2_WATCHDOG_EN
    // run_cycles lags by one, so the compare fires during the TIMEOUT_CYCLES-th run cycle
    assign expired = en && run_cycles == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
`else
    assign expired = 1'b0;
`endif
endmodule

// File: rtl/diagv2_run_ctrl.sv
// diagv2_run_ctrl: regression sequencer that loads, resets, runs and scores a list of core tests.
//   clk, reset          : clock, asynchronous active-high reset
//   start, num_tests    : begin a sequence of num_tests tests (sampled in IDLE/DONE)
//   bus (master)        : loader handshake and core reset/enable/ecall/status
//   busy, done          : sequence in progress / sequence complete
//   pass_cnt, fail_cnt  : scored tests
//   last_status         : status of the most recently scored test
//   timeout_seen        : sticky watchdog flag (DIAGV2_WATCHDOG_EN only, else 0)
//   run_cycles          : run cycles of the current/last test, saturating
module diagv2_run_ctrl import diagv2_run_ctrl_pkg::*; #(
    parameter int DATA_W         = DATA_BUS_BITS,
    parameter int IDX_W          = 8,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_W      = 20,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IDX_W-1:0]     num_tests,
    diagv2_run_ctrl_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     pass_cnt,
    output logic [IDX_W-1:0]     fail_cnt,
    output logic [DATA_W-1:0]    last_status,
    output logic                 timeout_seen,
    output logic [TIMEOUT_W-1:0] run_cycles
);
    state_t state, next;
    logic [IDX_W-1:0] count, idx;
    logic go, last, hold_zero, expired, in_run;
    assign go     = start && (state == S_IDLE || state == S_DONE);
    assign last   = idx + IDX_W'(1) == count;
    assign in_run = state == S_RUN;
    assign bus.load_idx = idx;
    diagv2_run_timer #(
        .TIMEOUT_W(TIMEOUT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .RESET_CYCLES(RESET_CYCLES)
    ) u_timer (
        .clk(clk),
        .reset(reset),
        .clr(state == S_RST),
        .en(in_run),
        .hold_load(state == S_LOAD && bus.load_ack),
        .hold_dec(state == S_RST),
        .hold_zero(hold_zero),
        .run_cycles(run_cycles),
        .expired(expired)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= next;
    end
    always_comb begin
        next           = state;
        bus.load_req   = state == S_LOAD;
        bus.core_reset = state inside {S_IDLE, S_LOAD, S_RST, S_DONE};
        bus.core_en    = state inside {S_RST, S_RUN};
        busy           = !(state inside {S_IDLE, S_DONE});
        done           = state == S_DONE;
        case (state)
            S_IDLE, S_DONE: next = go ? (num_tests == '0 ? S_DONE : S_LOAD) : state;
            S_LOAD:         next = bus.load_ack ? S_RST : S_LOAD;
            S_RST:          next = hold_zero ? S_RUN : S_RST;
            S_RUN:          next = (bus.ecall || expired) ? S_RECORD : S_RUN;
            S_RECORD:       next = last ? S_DONE : S_LOAD;
            default:        next = S_IDLE;
        endcase
    end
    // ecall takes priority over a same-cycle watchdog expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            idx         <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            last_status <= '0;
        end else if (go) begin
            count    <= num_tests;
            idx      <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (in_run && bus.ecall) begin
            last_status <= bus.status_code;
            pass_cnt    <= bus.status_code == '0 ? pass_cnt + IDX_W'(1) : pass_cnt;
            fail_cnt    <= bus.status_code != '0 ? fail_cnt + IDX_W'(1) : fail_cnt;
        end else if (in_run && expired) begin
            last_status <= '1;
            fail_cnt    <= fail_cnt + IDX_W'(1);
        end else if (state == S_RECORD && !last) begin
            idx <= idx + IDX_W'(1);
        end
    end
`ifdef DIAGV2_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) timeout_seen <= 1'b0;
        else if (go) timeout_seen <= 1'b0;
        else if (in_run && expired && !bus.ecall) timeout_seen <= 1'b1;
    end
`else
    assign timeout_seen = 1'b0;
`endif
endmodule

// File: doc/diagv2_run_ctrl.md
# diagv2_run_ctrl

Hardware regression sequencer for the diag-v2 pipelined core. It runs a list of test programs back-to-back: for each test it requests a program/data load, holds the core in reset, then releases it and runs until `ecall`. It captures the `a0` status code, scores pass or fail, and halts the core. It sits beside `diagv2_top`, drives the core's reset and clock-enable, and talks to an external memory loader through a req/ack handshake.

## Interface
Parameters:
- `DATA_W`, `` `DataBusBits ``: width of the status code.
- `IDX_W`, 8: width of the test index, test count and pass/fail counters.
- `RESET_CYCLES`, 4: cycles `core_reset` stays asserted before each run (≥1).
- `TIMEOUT_W`, 20: width of the run-cycle counter.
- `TIMEOUT_CYCLES`, 1000000: watchdog limit in run cycles (< 2^TIMEOUT_W).

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high. Forces the IDLE state and the reset values of all outputs.
- `start`, in, 1: single-cycle pulse. Sampled only in IDLE or DONE.
- `num_tests`, in, IDX_W: number of tests to run. Sampled on `start`.
- `load_req`, out, 1: load request to the loader.
- `load_idx`, out, IDX_W: index of the test to load. Stable while `load_req` is high.
- `load_ack`, in, 1: loader has finished filling imem/dmem.
- `core_reset`, out, 1: drives the core's `reset`.
- `core_en`, out, 1: core clock-enable. 0 halts the core.
- `ecall`, in, 1: core ecall indication.
- `status_code`, in, DATA_W: core a0/x10.
- `busy`, out, 1: a sequence is in progress.
- `done`, out, 1: sequence complete. Held high until the next `start`.
- `pass_cnt`, out, IDX_W: tests that passed.
- `fail_cnt`, out, IDX_W: tests that failed.
- `last_status`, out, DATA_W: status code of the most recently scored test.
- `timeout_seen`, out, 1: sticky flag; at least one test timed out.
- `run_cycles`, out, TIMEOUT_W: cycles spent in RUN by the current/last test. Saturates at its maximum value.

## Operation
- FSM states: IDLE, LOAD, RST, RUN, RECORD, DONE.
- IDLE / DONE:
  - `core_reset`=1, `core_en`=0.
  - On `start`: clear `pass_cnt`, `fail_cnt`, `timeout_seen` and `load_idx`; latch `num_tests`.
  - If `num_tests`==0 go to DONE, otherwise go to LOAD.
- LOAD:
  - `load_req`=1, `core_reset`=1, `core_en`=0.
  - When `load_ack` is sampled high: drop `load_req` and go to RST.
- RST:
  - `core_reset`=1, `core_en`=1, for exactly RESET_CYCLES cycles.
  - Then go to RUN and clear `run_cycles`.
- RUN:
  - `core_reset`=0, `core_en`=1; `run_cycles` increments each cycle.
  - On `ecall` high: capture `status_code` into `last_status`; increment `pass_cnt` if the status is zero, otherwise increment `fail_cnt`; go to RECORD.
  - On watchdog expiry (`run_cycles`==TIMEOUT_CYCLES-1, no ecall): increment `fail_cnt`, set `timeout_seen`, set `last_status` to all ones, go to RECORD.
  - If `ecall` and expiry occur in the same cycle, `ecall` wins.
- RECORD:
  - One cycle, `core_en`=0.
  - If `load_idx`+1 == latched count, go to DONE. Otherwise increment `load_idx` and go to LOAD.
- DONE: `done`=1, `busy`=0.
- `busy`=1 in every state except IDLE and DONE.
- `start` is ignored while busy.
- `load_ack` is ignored outside LOAD.
- Counters wrap modulo 2^IDX_W. The latched count bounds them, so wrap never occurs in a legal run.
- Reset values: `core_reset`=1, `core_en`=0, `load_req`=0, `done`=0, `busy`=0, `timeout_seen`=0. `load_idx`, `pass_cnt`, `fail_cnt`, `last_status` and `run_cycles` are all 0.

## Timing
- All outputs are registered or decoded from state only; no output depends combinationally on an input.
- `start` at edge N gives `load_req`=1 after edge N+1.
- `load_ack` sampled at edge M gives `core_reset`=1 with `core_en`=1 from M+1 to M+RESET_CYCLES; the core runs from M+RESET_CYCLES+1.
- `ecall` sampled at edge E:
  - `core_en`=0 from E+1, so the core executes no instruction after the ecall cycle.
  - Counters and `last_status` are valid after E+1.
- Per-test overhead excluding loader latency: RESET_CYCLES+3 cycles.
- `reset` asserted mid-operation puts all outputs at their reset values immediately, without waiting for a clock edge, and aborts any pending load request.

## Configuration
- `DIAGV2_WATCHDOG_EN` defined: watchdog active as described; `timeout_seen` functional.
- Not defined:
  - No expiry compare is built.
  - RUN exits only on `ecall`.
  - `timeout_seen` is tied to 0.
  - `run_cycles` still counts and saturates.

## Structure
- FSM state encodings and the all-ones timeout status constant go in `diagv2_const.vh` beside `` `DataBusBits ``.
- One sub-module, `diagv2_run_timer`:
  - holds the saturating `run_cycles` counter (clear, enable);
  - holds the reset-hold down-counter;
  - produces the `expired` flag (only under `DIAGV2_WATCHDOG_EN`).
- The FSM and scoring logic stay in `diagv2_run_ctrl`.

## Test plan
- `num_tests`=3; loader acks 2 cycles after each `load_req`; core ecalls with status 0, 0, 5 → `pass_cnt`=2, `fail_cnt`=1, `last_status`=5, `done`=1, `load_idx`=2.
- RESET_CYCLES=4, single test → `core_reset`=1 for exactly 4 cycles after `load_ack` with `core_en`=1, then `core_reset`=0.
- With the watchdog enabled, TIMEOUT_CYCLES=100, `ecall` never asserted → after 100 RUN cycles `fail_cnt`=1, `timeout_seen`=1, `last_status`=all ones, `core_en`=0.
- `ecall` with status 0 on the same cycle as expiry → `pass_cnt`=1, `timeout_seen`=0.
- `reset` pulsed mid-RUN of test 1 of 3 → `busy`=0, `core_reset`=1, counters 0 with no clock edge; a new `start` reruns from `load_idx`=0.
- `num_tests`=0 → `done`=1 one cycle after `start`, `load_req` never asserted, counters 0.
